sobel_window_gen: RTL

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_pkg.sv | 41 ++++
 rtl/sobel_line_buffer.sv | 49 ++++
 rtl/sobel_window_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window generator: the raw pixel type, the
// eight-neighbour window struct and the byte index of each neighbour.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_PIX = 8;
  localparam int WIN_W   = PIX_W * WIN_PIX;

  typedef logic [PIX_W-1:0] pixel_t;

  // The first member is the most significant byte. As a result, p00 sits in
  // byte 0 of the flattened window and p22 sits in byte 7.
  typedef struct packed {
    pixel_t p22;
    pixel_t p21;
    pixel_t p20;
    pixel_t p12;
    pixel_t p10;
    pixel_t p02;
    pixel_t p01;
    pixel_t p00;
  } window_t;

  // Byte position of each neighbour inside the flattened window.
  localparam int P00_IDX = 0;
  localparam int P01_IDX = 1;
  localparam int P02_IDX = 2;
  localparam int P10_IDX = 3;
  localparam int P12_IDX = 4;
  localparam int P20_IDX = 5;
  localparam int P21_IDX = 6;
  localparam int P22_IDX = 7;

  // Extract one neighbour from a window by its byte index.
  function automatic pixel_t win_pixel(input window_t w, input int idx);
    logic [WIN_W-1:0] flat;
    flat = w;
    return flat[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of delay. Every enabled shift writes din and presents the
// pixel that was written DEPTH shifts earlier, which is the same column one
// row up. The store is circular and uses a single read/write pointer.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr,
  input  logic   shift_en,
  input  pixel_t din,
  output pixel_t dout
);

  localparam int PW = $clog2(DEPTH);

  pixel_t          mem [DEPTH];
  logic   [PW-1:0] ptr_q;

  // The oldest entry lives at the pointer, so it is read before it is overwritten.
  assign dout = mem[ptr_q];

  // Advance the pointer on every shift; a new frame realigns it to column 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (shift_en) begin
      ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  // Row storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset. No window is built
    // before two full rows of the current frame have been written, so stale
    // contents are never observed, and leaving it unreset keeps it mappable
    // to RAM.
    if (shift_en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator for a Sobel kernel. Pixels arrive in
// row-major order. Two line buffers and a three-column shift window form the
// neighbourhood around every interior pixel. Windows leave through a
// single-entry valid/ready output register.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  pix_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic [63:0] win_o,
  output logic        win_valid_o,
  input  logic        win_ready_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          done_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic    frame_start;
  logic    pix_accept;
  logic    last_col;
  logic    last_row;
  logic    win_load;

  pixel_t  lb0_out, lb1_out;
  pixel_t  top_c1, top_c2, mid_c1, mid_c2, bot_c1, bot_c2;
  window_t win_next, win_q;

  assign frame_start = (state_q == ST_IDLE) && start_i;
  assign pix_ready_o = (state_q == ST_STREAM) && (!win_valid_o || win_ready_i);
  assign pix_accept  = pix_valid_i && pix_ready_o;
  assign last_col    = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row    = (row_q == RW'(IMG_HEIGHT - 1));
  // A full window exists only once two rows and two columns of context are present.
  assign win_load    = pix_accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign busy_o = (state_q != ST_IDLE);
  assign win_o  = win_q;

  // Next-state logic for the frame sequencer.
  always_comb begin
    // NOTE: every output of this block is assigned a default first, so that
    // no path through the case statement infers a latch.
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pix_accept && last_col && last_row) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Hold DRAIN through the done pulse, so busy_o falls one cycle later.
        if (frame_done_o)      state_d = ST_IDLE;
        else if (!win_valid_o) done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered frame-done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_o <= done_d;
    end
  end

  // Raster position of the next pixel. Start is honoured only in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else if (frame_start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // lb0 yields the pixel one row above the incoming pixel; lb1 yields the pixel two rows above.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr      (frame_start),
    .shift_en (pix_accept),
    .din      (pix_i),
    .dout     (lb0_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr      (frame_start),
    .shift_en (pix_accept),
    .din      (lb0_out),
    .dout     (lb1_out)
  );

  // Keep the previous two columns of each of the three rows.
  // At columns 0 and 1 this window holds data from the prior row, but
  // win_load is never true there, so that data is never emitted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_c1 <= '0;
      top_c2 <= '0;
      mid_c1 <= '0;
      mid_c2 <= '0;
      bot_c1 <= '0;
      bot_c2 <= '0;
    end else if (pix_accept) begin
      top_c1 <= lb1_out;
      top_c2 <= top_c1;
      mid_c1 <= lb0_out;
      mid_c2 <= mid_c1;
      bot_c1 <= pix_i;
      bot_c2 <= bot_c1;
    end
  end

  // Build the window whose top-left is (row-2, col-2). The centre pixel (mid_c1) is not output.
  always_comb begin
    win_next.p00 = top_c2;
    win_next.p01 = top_c1;
    win_next.p02 = lb1_out;
    win_next.p10 = mid_c2;
    win_next.p12 = lb0_out;
    win_next.p20 = bot_c2;
    win_next.p21 = bot_c1;
    win_next.p22 = pix_i;
  end

  // Single-entry output stage. A load takes priority over consumption, so
  // win_valid_o stays high under continuous flow; a stalled window is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q       <= '0;
      win_valid_o <= 1'b0;
    end else if (win_load) begin
      win_q       <= win_next;
      win_valid_o <= 1'b1;
    end else if (win_ready_i) begin
      win_valid_o <= 1'b0;
    end
  end

endmodule
